// File: rtl/cp0_timer_unit.sv
// Purpose : CP0 Count/Compare timer with MTC0 write / MFC0 read access and a sticky IP7 interrupt.
// Latency : reads return 1 cycle after r_p; writes become visible 1 cycle after we; timer_irq is registered.
// Backpres: none -- every access completes in a single cycle, so no stall path exists.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   we         MTC0 write strobe; waddr selects Count (9) or Compare (11); wdata is the value
//   r_p        MFC0 read strobe; raddr selects the register; read_data holds the registered result
//   halt       freezes Count and its prescaler while high (writes still land)
//   timer_irq  sticky timer interrupt, set when Count ticks onto Compare, cleared by a Compare write

module cp0_timer_unit #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        r_p,
    input  logic [4:0]  raddr,
    output logic [31:0] read_data,
    input  logic        halt,
    output logic        timer_irq
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [3:0] DIV_LAST    = 4'(COUNT_DIV - 1);

    logic [31:0] count;
    logic [31:0] compare;
    logic [3:0]  div_cnt;

    logic        count_wr;
    logic        compare_wr;
    logic        tick;
    logic [31:0] count_inc;
    logic        irq_set;

    assign count_wr   = we && (waddr == REG_COUNT);
    assign compare_wr = we && (waddr == REG_COMPARE);

    // A prescaler wrap advances Count, unless frozen or overridden by a Count write.
    assign tick      = !halt && !count_wr && (div_cnt == DIV_LAST);
    assign count_inc = count + 32'd1;

    // Only a real increment can raise the interrupt; loading Count with the
    // Compare value through MTC0 deliberately does not.
    assign irq_set = tick && (count_inc == compare);

    // Count and prescaler
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 32'd0;
            div_cnt <= 4'd0;
        end else if (count_wr) begin
            count   <= wdata;
            div_cnt <= 4'd0;
        end else if (!halt) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= 4'd0;
                count   <= count_inc;   // wraps silently past 0xFFFFFFFF
            end else begin
                div_cnt <= div_cnt + 4'd1;
            end
        end
    end

    // Compare register
    always_ff @(posedge clk) begin
        if (rst) begin
            compare <= 32'hFFFF_FFFF;
        end else if (compare_wr) begin
            compare <= wdata;
        end
    end

    // Sticky interrupt; the Compare-write clear wins over a coincident set.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_irq <= 1'b0;
        end else if (compare_wr) begin
            timer_irq <= 1'b0;
        end else if (irq_set) begin
            timer_irq <= 1'b1;
        end
    end

    // Read port samples the pre-edge register values, so a read coincident
    // with a write to the same register returns the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= 32'd0;
        end else if (r_p) begin
            case (raddr)
                REG_COUNT:   read_data <= count;
                REG_COMPARE: read_data <= compare;
                default:     read_data <= 32'd0;
            endcase
        end
    end

endmodule
